// File: rtl/dsp_seq_pkg.sv
// Purpose: shared types and helpers for the DSP frame sequencer and its metering neighbours.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   seq_state_t   - sequencer state encoding (IDLE, WAIT_SYNC, RUN, HOLD)
//   calc_pc_width - pc width needed for the instruction slots available per audio frame
package dsp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } seq_state_t;

    // Slots per frame is the DSP clock divided by the sample rate; never narrower than 1 bit.
    function automatic int calc_pc_width(input int dsp_khz, input int fs_khz);
        int slots;
        slots = dsp_khz / fs_khz;
        return (slots <= 2) ? 1 : $clog2(slots);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Purpose: saturating event counter with synchronous clear; a clear and an increment in the same cycle leave the count at 1.
// Latency: count reflects an event one clk after it is presented.
// Backpressure: none; every i_inc is absorbed, counts beyond all-ones are dropped.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   i_inc       - count one event this cycle
//   i_clr       - clear the count this cycle
//   o_count     - registered count, saturates at all ones
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && i_clr) begin
            r_count <= WIDTH'(1);
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/dsp_frame_sequencer.sv
// Purpose: steps the DSP program counter 0..PROG_LEN-1 once per audio frame, aligned to frame_sync (or free-running).
// Latency: pc=0 appears one clk after the frame_sync that starts a frame; all outputs registered.
// Backpressure: none; early syncs restart the program and are flagged as overruns.
//
// Ports: clk/reset (sync, active-high); run (level enable); frame_sync, clear_flags (1-cycle pulses);
//   pc/pc_valid/frame_start/frame_end (slot stream); frame_count, overrun, overrun_count, sync_lost (status).
// Optional: define DSP_SEQ_WATCHDOG_EN to build the missing-sync watchdog; otherwise sync_lost is tied to 0.
module dsp_frame_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int PC_WIDTH      = 11,
    parameter int PROG_LEN      = 2048,
    parameter int FREE_RUN      = 0,
    parameter int FCNT_WIDTH    = 16,
    parameter int OVR_CNT_WIDTH = 8,
    parameter int WDOG_CYCLES   = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     frame_sync,
    input  logic                     clear_flags,
    output logic [PC_WIDTH-1:0]      pc,
    output logic                     pc_valid,
    output logic                     frame_start,
    output logic                     frame_end,
    output logic [FCNT_WIDTH-1:0]    frame_count,
    output logic                     overrun,
    output logic [OVR_CNT_WIDTH-1:0] overrun_count,
    output logic                     sync_lost
);

    generate
        if (PROG_LEN < 2) begin : g_bad_len
            $error("dsp_frame_sequencer: PROG_LEN must be at least 2");
        end
        if (PROG_LEN > (2 ** PC_WIDTH)) begin : g_bad_width
            $error("dsp_frame_sequencer: PROG_LEN does not fit in PC_WIDTH bits");
        end
        if (WDOG_CYCLES < 1) begin : g_bad_wdog
            $error("dsp_frame_sequencer: WDOG_CYCLES must be at least 1");
        end
    endgenerate

    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(PROG_LEN - 1);
    localparam bit                  FR      = (FREE_RUN != 0);

    seq_state_t            r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic                  r_pc_valid;
    logic                  r_frame_start;
    logic                  r_frame_end;
    logic [FCNT_WIDTH-1:0] r_frame_count;
    logic                  r_overrun;

    logic                  w_sync;
    logic                  w_at_last;
    logic                  w_ovr_evt;
    logic                  w_wdog_trip;
    logic [PC_WIDTH-1:0]   w_pc_next;

    // Free-running builds never look at frame_sync.
    assign w_sync    = frame_sync && !FR;
    assign w_at_last = (r_state == RUN) && (r_pc == LAST_PC);
    assign w_ovr_evt = (r_state == RUN) && w_sync && (r_pc != LAST_PC);
    assign w_pc_next = r_pc + 1'b1;

`ifdef DSP_SEQ_WATCHDOG_EN
    localparam int              WD_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_TRIP = WD_W'(WDOG_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_CYCLES);

    logic [WD_W-1:0] r_wdog_cnt;
    logic            r_sync_lost;
    logic            w_wd_active;

    assign w_wd_active = !FR && (r_state != IDLE);
    // Trip on the edge that completes WDOG_CYCLES sync-less cycles.
    assign w_wdog_trip = w_wd_active && !frame_sync && (r_wdog_cnt == WD_TRIP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog_cnt  <= '0;
            r_sync_lost <= 1'b0;
        end else begin
            if (!w_wd_active || frame_sync) begin
                r_wdog_cnt <= '0;
            end else if (r_wdog_cnt != WD_MAX) begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
            end
            if (w_wdog_trip) begin
                r_sync_lost <= 1'b1;
            end else if (clear_flags || w_sync) begin
                r_sync_lost <= 1'b0;
            end
        end
    end

    assign sync_lost = r_sync_lost;
`else
    assign w_wdog_trip = 1'b0;
    assign sync_lost   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= '0;
            r_pc_valid    <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_count <= '0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;

            // Only frames that reach their last slot are counted; truncated or abandoned ones are not.
            if (w_at_last && !w_wdog_trip) begin
                r_frame_count <= r_frame_count + 1'b1;
            end

            if (w_ovr_evt) begin
                r_overrun <= 1'b1;
            end else if (clear_flags) begin
                r_overrun <= 1'b0;
            end

            if (w_wdog_trip) begin
                r_state    <= WAIT_SYNC;
                r_pc_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (run) begin
                            if (FR) begin
                                r_state       <= RUN;
                                r_pc          <= '0;
                                r_pc_valid    <= 1'b1;
                                r_frame_start <= 1'b1;
                            end else begin
                                r_state <= WAIT_SYNC;
                            end
                        end
                    end
                    WAIT_SYNC, HOLD: begin
                        if (!run) begin
                            r_state <= IDLE;
                        end else if (w_sync) begin
                            r_state       <= RUN;
                            r_pc          <= '0;
                            r_pc_valid    <= 1'b1;
                            r_frame_start <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (w_at_last) begin
                            if (!run) begin
                                r_state    <= IDLE;
                                r_pc_valid <= 1'b0;
                            end else if (FR || w_sync) begin
                                r_pc          <= '0;
                                r_frame_start <= 1'b1;
                            end else begin
                                // pc parks on the last slot while waiting for a late sync.
                                r_state    <= HOLD;
                                r_pc_valid <= 1'b0;
                            end
                        end else if (w_ovr_evt) begin
                            r_pc          <= '0;
                            r_frame_start <= 1'b1;
                        end else begin
                            r_pc        <= w_pc_next;
                            r_frame_end <= (w_pc_next == LAST_PC);
                        end
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_pc_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH (OVR_CNT_WIDTH)
    ) u_ovr_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_ovr_evt),
        .i_clr   (clear_flags),
        .o_count (overrun_count)
    );

    assign pc          = r_pc;
    assign pc_valid    = r_pc_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign frame_count = r_frame_count;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_dsp_frame_sequencer.sv
// Purpose: self-checking bench for dsp_frame_sequencer (sync-aligned and free-running instances, PROG_LEN=6).
// Latency: n/a.
// Backpressure: n/a.
module tb_dsp_frame_sequencer;

    typedef struct packed {
        logic [2:0] pc;
        logic       st;
        logic       en;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // sync-aligned instance
    logic        reset = 1'b1, run = 1'b0, frame_sync = 1'b0, clear_flags = 1'b0;
    logic [2:0]  pc;
    logic        pc_valid, frame_start, frame_end, overrun, sync_lost;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;

    // free-running instance
    logic        fr_reset = 1'b1, fr_run = 1'b0, fr_sync = 1'b0, fr_clear = 1'b0;
    logic [2:0]  fr_pc;
    logic        fr_pc_valid, fr_frame_start, fr_frame_end, fr_overrun, fr_sync_lost;
    logic [15:0] fr_frame_count;
    logic [7:0]  fr_overrun_count;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q_main[$];
    exp_t q_fr[$];
    exp_t e_main, e_fr;

    dsp_frame_sequencer #(
        .PC_WIDTH(3), .PROG_LEN(6), .FREE_RUN(0), .FCNT_WIDTH(16), .OVR_CNT_WIDTH(8), .WDOG_CYCLES(20)
    ) u_dut (
        .clk(clk), .reset(reset), .run(run), .frame_sync(frame_sync), .clear_flags(clear_flags),
        .pc(pc), .pc_valid(pc_valid), .frame_start(frame_start), .frame_end(frame_end),
        .frame_count(frame_count), .overrun(overrun), .overrun_count(overrun_count), .sync_lost(sync_lost)
    );

    dsp_frame_sequencer #(
        .PC_WIDTH(3), .PROG_LEN(6), .FREE_RUN(1), .FCNT_WIDTH(16), .OVR_CNT_WIDTH(8), .WDOG_CYCLES(20)
    ) u_fr (
        .clk(clk), .reset(fr_reset), .run(fr_run), .frame_sync(fr_sync), .clear_flags(fr_clear),
        .pc(fr_pc), .pc_valid(fr_pc_valid), .frame_start(fr_frame_start), .frame_end(fr_frame_end),
        .frame_count(fr_frame_count), .overrun(fr_overrun), .overrun_count(fr_overrun_count),
        .sync_lost(fr_sync_lost)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected slots of one complete frame, in order.
    task automatic push_frame(input bit to_fr);
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            e.pc = 3'(i);
            e.st = (i == 0);
            e.en = (i == 5);
            if (to_fr) q_fr.push_back(e);
            else       q_main.push_back(e);
        end
    endtask

    // A sync seen while pc==keep truncates the frame: later slots never appear.
    task automatic truncate_main(input int keep);
        while (q_main.size() > 0 && int'(q_main[$].pc) > keep) begin
            void'(q_main.pop_back());
        end
    endtask

    // Scoreboard: every executing slot must match the oldest expectation.
    always @(negedge clk) begin
        if (pc_valid === 1'b1) begin
            chk("main_slot_expected", 32'(q_main.size() != 0), 1);
            if (q_main.size() != 0) begin
                e_main = q_main.pop_front();
                chk("main_pc", pc, e_main.pc);
                chk("main_frame_start", frame_start, e_main.st);
                chk("main_frame_end", frame_end, e_main.en);
            end
        end else begin
            chk("main_start_when_invalid", frame_start, 0);
            chk("main_end_when_invalid", frame_end, 0);
        end
        if (fr_pc_valid === 1'b1) begin
            chk("fr_slot_expected", 32'(q_fr.size() != 0), 1);
            if (q_fr.size() != 0) begin
                e_fr = q_fr.pop_front();
                chk("fr_pc", fr_pc, e_fr.pc);
                chk("fr_frame_start", fr_frame_start, e_fr.st);
                chk("fr_frame_end", fr_frame_end, e_fr.en);
            end
        end else begin
            chk("fr_start_when_invalid", fr_frame_start, 0);
            chk("fr_end_when_invalid", fr_frame_end, 0);
        end
    end

    initial begin
        // reset for two cycles
        tick(); tick();
        chk("rst_pc", pc, 0);
        chk("rst_pc_valid", pc_valid, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_overrun_count", overrun_count, 0);
        chk("rst_sync_lost", sync_lost, 0);
        reset = 1'b0;
        run   = 1'b1;
        tick();
        chk("wait_sync_invalid", pc_valid, 0);

        // three frames, sync every 10 cycles: 6 slots then 4 HOLD cycles
        for (int f = 0; f < 3; f++) begin
            frame_sync = 1'b1;
            push_frame(0);
            tick();
            frame_sync = 1'b0;
            repeat (9) tick();
            chk("hold_pc_valid", pc_valid, 0);
            chk("hold_pc", pc, 5);
        end
        chk("fc_after_3", frame_count, 3);
        chk("q_empty_after_3", q_main.size(), 0);

        // on-time sync in the pc=5 cycle: wrap with no HOLD
        frame_sync = 1'b1;
        push_frame(0);
        tick();
        frame_sync = 1'b0;
        repeat (5) tick();
        frame_sync = 1'b1;
        push_frame(0);
        tick();
        frame_sync = 1'b0;
        chk("ontime_pc", pc, 0);
        chk("ontime_valid", pc_valid, 1);
        chk("ontime_overrun", overrun, 0);
        chk("ontime_fc", frame_count, 4);

        // early sync while pc=3
        repeat (3) tick();
        chk("pre_ovr_pc", pc, 3);
        frame_sync = 1'b1;
        truncate_main(3);
        push_frame(0);
        tick();
        frame_sync = 1'b0;
        chk("ovr_pc", pc, 0);
        chk("ovr_flag", overrun, 1);
        chk("ovr_count", overrun_count, 1);
        chk("ovr_fc_unchanged", frame_count, 4);

        // clear_flags together with a new early sync: set wins, count restarts at 1
        repeat (2) tick();
        frame_sync  = 1'b1;
        clear_flags = 1'b1;
        truncate_main(2);
        push_frame(0);
        tick();
        frame_sync  = 1'b0;
        clear_flags = 1'b0;
        chk("clr_set_flag", overrun, 1);
        chk("clr_set_count", overrun_count, 1);

        // 300 back-to-back early syncs: count saturates
        frame_sync = 1'b1;
        truncate_main(0);
        for (int i = 0; i < 300; i++) begin
            q_main.push_back('{pc: 3'd0, st: 1'b1, en: 1'b0});
            tick();
        end
        frame_sync = 1'b0;
        for (int i = 1; i < 6; i++) q_main.push_back('{pc: 3'(i), st: 1'b0, en: (i == 5)});
        chk("sat_count", overrun_count, 255);
        chk("sat_fc", frame_count, 4);

        // run=0 mid-frame: finish the frame, then IDLE
        run = 1'b0;
        repeat (5) tick();
        chk("stop_last_pc", pc, 5);
        tick();
        chk("stop_idle_valid", pc_valid, 0);
        chk("stop_fc", frame_count, 5);

        // clear_flags alone
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("clr_flag", overrun, 0);
        chk("clr_count", overrun_count, 0);

        // reset mid-frame at pc=4: no frame_end, counters back to 0
        run = 1'b1;
        tick();
        frame_sync = 1'b1;
        push_frame(0);
        tick();
        frame_sync = 1'b0;
        repeat (4) tick();
        chk("pre_rst_pc", pc, 4);
        truncate_main(4);
        reset = 1'b1;
        tick();
        chk("midrst_pc", pc, 0);
        chk("midrst_valid", pc_valid, 0);
        chk("midrst_fc", frame_count, 0);
        tick();
        reset = 1'b0;

        // sync drought
        tick();
        frame_sync = 1'b1;
        push_frame(0);
        tick();
        frame_sync = 1'b0;
        repeat (19) tick();
        chk("drought19_sync_lost", sync_lost, 0);
        chk("drought19_valid", pc_valid, 0);
        tick();
`ifdef DSP_SEQ_WATCHDOG_EN
        chk("wdog_sync_lost", sync_lost, 1);
        chk("wdog_valid", pc_valid, 0);
`else
        chk("nowdog_sync_lost", sync_lost, 0);
        chk("nowdog_hold_pc", pc, 5);
`endif
        frame_sync = 1'b1;
        push_frame(0);
        tick();
        frame_sync = 1'b0;
        chk("resync_pc", pc, 0);
        chk("resync_start", frame_start, 1);
        chk("resync_sync_lost", sync_lost, 0);
        run = 1'b0;
        repeat (6) tick();
        chk("resync_fc", frame_count, 2);
        chk("q_main_empty", q_main.size(), 0);

        // free-running instance, frame_sync held high (ignored)
        fr_reset = 1'b0;
        fr_run   = 1'b1;
        fr_sync  = 1'b1;
        push_frame(1); push_frame(1); push_frame(1);
        repeat (13) tick();
        chk("fr_fc_12", fr_frame_count, 2);
        chk("fr_pc_wrap", fr_pc, 0);
        repeat (2) tick();
        chk("fr_pc2", fr_pc, 2);
        fr_run = 1'b0;
        repeat (4) tick();
        chk("fr_idle_valid", fr_pc_valid, 0);
        chk("fr_fc_end", fr_frame_count, 3);
        chk("fr_overrun", fr_overrun, 0);
        chk("fr_overrun_count", fr_overrun_count, 0);
        chk("fr_sync_lost", fr_sync_lost, 0);
        chk("q_fr_empty", q_fr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
